// File: rtl/ps2_keyboard_receiver_pkg.sv
// Shared PS/2 receive definitions: frame layout, well-known scancodes, FSM states.
// The frame check is shared so that other PS/2 blocks validate frames the same way.
package ps2_keyboard_receiver_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED   = 8'hE0;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_DATA  = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  // Bit 0 is the start bit; the frame is shifted in LSB first.
  function automatic logic frame_good(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && (^f[9:1] == 1'b1) && (f[10] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-around pointers.
// The block is generic so it can also be used in other receive paths, such as a UART.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host receiver: it synchronises and filters the pins, frames the bits,
// and checks parity. Good scancodes are queued in the FIFO.
//
// state    | meaning
// RX_IDLE  | waiting for a falling clock edge with data low (start bit)
// RX_DATA  | shifting in data, parity and stop bits; guarded by timeout
// RX_CHECK | one cycle to validate the frame and push or flag it
module ps2_keyboard_receiver
  import ps2_keyboard_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          rd_en,
  input  logic                          clear_errors,
  output logic [7:0]                    scancode,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(PS2_FRAME_BITS - 1);

  logic                      clk_s1, clk_s2, dat_s1, dat_s2;
  logic                      clk_filt, clk_filt_d;
  logic [FW-1:0]             filt_cnt;
  logic                      fall;
  rx_state_t                 state;
  logic [3:0]                bit_cnt;
  logic [PS2_FRAME_BITS-1:0] shift;
  logic [TW-1:0]             tmo_cnt;
  logic                      push;
  logic                      fifo_full;
  logic                      fifo_empty;

  // The pins idle high, so the synchronizer and filter start at 1 and reset does not create a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_dat;
      dat_s2     <= dat_s1;
      clk_filt_d <= clk_filt;
      if (clk_s2 != clk_filt) begin
        if (filt_cnt == FILT_LAST) begin
          clk_filt <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;
  assign push = (state == RX_CHECK) && frame_good(shift);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RX_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      tmo_cnt     <= '0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      // Any error raised below overrides a simultaneous clear.
      if (clear_errors) begin
        overflow    <= 1'b0;
        frame_error <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          tmo_cnt <= '0;
          if (fall && !dat_s2) begin
            shift   <= {dat_s2, shift[PS2_FRAME_BITS-1:1]};
            bit_cnt <= 4'd1;
            state   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (fall) begin
            shift   <= {dat_s2, shift[PS2_FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            tmo_cnt <= '0;
            if (bit_cnt == BIT_LAST) state <= RX_CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= RX_IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            frame_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RX_CHECK: begin
          state   <= RX_IDLE;
          bit_cnt <= '0;
          tmo_cnt <= '0;
          if (!frame_good(shift))             frame_error <= 1'b1;
          else if (fifo_full && !rd_en)       overflow    <= 1'b1;
        end
        default: begin
          state   <= RX_IDLE;
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (rd_en),
    .wr_data (shift[8:1]),
    .rd_data (scancode),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Drives PS/2 frames onto the pins and compares the outputs against a queue-based model.
module tb_ps2_keyboard_receiver;
  import ps2_keyboard_receiver_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 20;
  localparam int Q          = HALF / 2;
  // The stop-bit fall is seen after 2 sync stages and FILTER_LEN filter samples. Valid then rises 2 cycles later.
  localparam int LAT        = 2 + FILTER_LEN + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] scancode;
  logic       valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       frame_error;

  ps2_keyboard_receiver #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .rd_en        (rd_en),
    .clear_errors (clear_errors),
    .scancode     (scancode),
    .valid        (valid),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_q[$];
  bit         m_ovf = 1'b0;
  bit         m_ferr = 1'b0;
  bit         chk_latency = 1'b0;
  bit         pop_on_check = 1'b0;
  logic [7:0] lat_exp = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par_ok, input bit stop);
    logic p;
    p = par_ok ? ~(^d) : ^d;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_bit(input logic b, input bit last);
    wait_clk(Q);
    ps2_dat = b;
    wait_clk(Q);
    ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk);
      #1;
      if (last && chk_latency && i == LAT - 1) check_val("lat_early_valid", valid, 1'b0);
      if (last && chk_latency && i == LAT) begin
        check_val("lat_valid", valid, 1'b1);
        check_val("lat_scancode", scancode, lat_exp);
      end
      if (last && pop_on_check && i == LAT - 1) rd_en = 1'b1;
      if (last && pop_on_check && i == LAT) rd_en = 1'b0;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == 10);
    ps2_dat = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_and_model(input logic [7:0] d, input bit par_ok, input bit stop);
    send_frame(make_frame(d, par_ok, stop), 11);
    if (par_ok && stop) begin
      if (pop_on_check && model_q.size() > 0) void'(model_q.pop_front());
      if (model_q.size() < FIFO_DEPTH) model_q.push_back(d);
      else m_ovf = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ".count"}, 32'(fifo_count), 32'(model_q.size()));
    check_val({tag, ".valid"}, valid, model_q.size() > 0);
    check_val({tag, ".scancode"}, scancode, model_q.size() > 0 ? model_q[0] : 8'h00);
    check_val({tag, ".overflow"}, overflow, m_ovf);
    check_val({tag, ".frame_error"}, frame_error, m_ferr);
  endtask

  task automatic pop_one(input string tag);
    check_val({tag, ".head"}, scancode, model_q[0]);
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (model_q.size() > 0) pop_one(tag);
    check_state({tag, ".drained"});
  endtask

  task automatic clear_err();
    clear_errors = 1'b1;
    wait_clk(1);
    clear_errors = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    wait_clk(3);
    check_state("reset");
    reset = 1'b1;
    wait_clk(5);

    chk_latency = 1'b1;
    lat_exp     = 8'h1C;
    send_and_model(8'h1C, 1'b1, 1'b1);
    chk_latency = 1'b0;
    check_state("t1");
    drain("t1");

    send_and_model(PS2_BREAK, 1'b1, 1'b1);
    send_and_model(8'h1C, 1'b1, 1'b1);
    check_state("t2");
    pop_one("t2.first");
    check_state("t2.after1");
    pop_one("t2.second");
    check_state("t2.after2");

    send_and_model(8'h1C, 1'b0, 1'b1);
    check_state("t3.parity");
    send_and_model(8'h1C, 1'b1, 1'b0);
    check_state("t3.stop");
    clear_err();
    check_state("t3.cleared");

    send_frame(make_frame(8'hA5, 1'b1, 1'b1), 6);
    wait_clk(TIMEOUT + 100);
    m_ferr = 1'b1;
    check_state("t4.timeout");
    clear_err();
    send_and_model(8'h29, 1'b1, 1'b1);
    check_state("t4.after");
    drain("t4");

    for (int i = 1; i <= 9; i++) send_and_model(8'(i), 1'b1, 1'b1);
    check_state("t5.full");
    drain("t5");
    clear_err();
    for (int i = 1; i <= 8; i++) send_and_model(8'(i), 1'b1, 1'b1);
    pop_on_check = 1'b1;
    send_and_model(8'h09, 1'b1, 1'b1);
    pop_on_check = 1'b0;
    check_state("t5.poppush");
    drain("t5b");

    send_and_model(8'h33, 1'b1, 1'b1);
    send_frame(make_frame(8'h77, 1'b1, 1'b1), 6);
    reset = 1'b0;
    wait_clk(3);
    check_val("t6.rst.count", 32'(fifo_count), 32'd0);
    check_val("t6.rst.valid", valid, 1'b0);
    check_val("t6.rst.scancode", scancode, 8'h00);
    check_val("t6.rst.errs", {overflow, frame_error}, 2'b00);
    model_q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    reset  = 1'b1;
    wait_clk(5);
    send_and_model(8'h5A, 1'b1, 1'b1);
    check_state("t6.after");
    drain("t6");

    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      int         kind;
      d    = (n % 7 == 3) ? PS2_EXTENDED : 8'($urandom);
      kind = int'($urandom_range(0, 5));
      send_and_model(d, kind != 0, kind != 1);
      if ($urandom_range(0, 2) == 0 && model_q.size() > 0) pop_one("rnd.pop");
      check_state("rnd");
      if ($urandom_range(0, 4) == 0) clear_err();
    end
    drain("rnd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
